mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Initiator side of the single-precision MAC issue/finish interface. Streams K (data, weight)
//  FP32 pairs into one MAC unit, one op in flight, feeding each returned accumulator back as
//  acc of the next op. Returns the final dot-product sum on a valid/ready result port.
//  Sits between the operand-fetch logic and a fused-multiply-add MAC unit.
// PARAMETERS
//  MaxLen  256                 largest supported dot-product length K
//  LenW    $clog2(MaxLen+1)    width of length/counter fields (derived; do not override)
// PORTS
//  clk_i           in   1     clock, rising edge
//  rst_ni          in   1     asynchronous active-low reset
//  start_i         in   1     start a dot product; sampled only in IDLE
//  len_i           in   LenW  K, number of pairs; sampled with start_i; 0..MaxLen
//  acc_init_i      in   32    FP32 initial accumulator; sampled with start_i
//  in_valid_i      in   1     operand pair valid
//  in_ready_o      out  1     operand pair accepted when in_valid_i && in_ready_o
//  data_i          in   32    FP32 data operand
//  weight_i        in   32    FP32 weight operand
//  mac_valid_o     out  1     one-cycle issue pulse to MAC; MAC never back-pressures
//  mac_data_o      out  32    FP32 data to MAC, registered
//  mac_weight_o    out  32    FP32 weight to MAC, registered
//  mac_acc_o       out  32    FP32 addend to MAC (running accumulator), registered
//  mac_finished_i  in   1     MAC result valid, one-cycle pulse
//  mac_acc_i       in   32    FP32 MAC result (data*weight+acc), valid with mac_finished_i
//  res_valid_o     out  1     final sum valid
//  res_ready_i     in   1     consumer accepts final sum
//  res_o           out  32    FP32 final sum
//  busy_o          out  1     high in every state except IDLE
//  spurious_o      out  1     sticky: mac_finished_i seen outside WAIT; cleared by reset only
// BEHAVIOUR
//  Reset: state=IDLE. Every output and internal register is 0, including counter, acc and
//   operand regs. Asserting rst_ni low mid-operation aborts it. Nothing is replayed.
//  FSM IDLE -> FETCH -> ISSUE -> WAIT -> (FETCH | DONE) -> IDLE:
//   IDLE : start_i=1 loads len, loads acc<=acc_init_i, sets cnt<=0.
//          Next state is FETCH, or DONE if len_i==0.
//   FETCH: in_ready_o=1. On a handshake, register data_i/weight_i into the mac_* regs -> ISSUE.
//   ISSUE: mac_valid_o=1 for exactly this cycle. mac_data/weight/acc_o hold stable -> WAIT.
//   WAIT : on mac_finished_i, acc<=mac_acc_i and cnt<=cnt+1.
//          Next state is DONE if cnt+1==len, else FETCH.
//   DONE : res_valid_o=1 and res_o=acc. Hold both until res_ready_i=1, then -> IDLE.
//  in_ready_o, mac_valid_o, res_valid_o and busy_o are Moore outputs (state decode only).
//  mac_*_o regs keep their last value outside ISSUE. Only the ISSUE-cycle value is meaningful.
//  MAC latency is not assumed. WAIT holds indefinitely until mac_finished_i.
//  Per-pair cost is 1 (FETCH, when in_valid_i is already high) + 1 (ISSUE) + L_mac cycles.
//  start_i outside IDLE is ignored. len_i > MaxLen is clamped to MaxLen.
//  mac_finished_i outside WAIT: result discarded, spurious_o<=1, state unchanged.
//  res_ready_i while DONE completes in one cycle. A start_i in that same cycle is ignored.
//   A new start is accepted at the earliest in the following IDLE cycle.
//  No FP arithmetic in this block. Values pass through bit-exact.
// TESTING (bench MAC model: FMA, RNE, configurable latency L, default L=2)
//  1 K=2, acc_init=0x00000000, data={0x3F800000,0x40000000} (1.0,2.0),
//    weight={0x40000000,0x40400000} (2.0,3.0)
//    -> 2 mac_valid_o pulses; second has mac_acc_o=0x40000000; res_o=0x41000000 (8.0).
//  2 K=0, acc_init=0x3FC00000 -> no in_ready_o, no mac_valid_o;
//    res_valid_o 1 cycle after start; res_o=0x3FC00000.
//  3 K=3 with in_valid_i gap of 5 cycles and res_ready_i held low 4 cycles
//    -> FETCH stalls with no issue; res_valid_o/res_o hold stable; exactly 3 issues.
//  4 Sweep L=1,2,7 at K=MaxLen, all pairs 1.0*1.0, acc_init 0 -> res_o=0x43800000 (256.0).
//    Check issue-to-issue spacing of L+2 cycles with in_valid_i held high.
//  5 Pulse mac_finished_i in IDLE and FETCH -> spurious_o=1 and stays 1; acc and state unchanged.
//    start_i pulsed during WAIT -> ignored.
//  6 rst_ni low during WAIT at K=4, cnt=2 -> all outputs 0, busy_o=0.
//    A new K=1 run afterwards gives the correct result.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: drives a single fused-multiply-add MAC unit through a dot product of
// K (data, weight) pairs, one operation in flight at a time. Each returned accumulator
// becomes the addend of the next operation, and the final sum is offered on a valid/ready
// result port. No floating-point arithmetic happens here; all values pass through bit-exact.
module mac_dot_sequencer #(
    parameter  int MaxLen = 256,
    localparam int LenW   = $clog2(MaxLen + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [LenW-1:0] len_i,
    input  logic [31:0]     acc_init_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     data_i,
    input  logic [31:0]     weight_i,
    output logic            mac_valid_o,
    output logic [31:0]     mac_data_o,
    output logic [31:0]     mac_weight_o,
    output logic [31:0]     mac_acc_o,
    input  logic            mac_finished_i,
    input  logic [31:0]     mac_acc_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [31:0]     res_o,
    output logic            busy_o,
    output logic            spurious_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [LenW-1:0] len;
    logic [LenW-1:0] cnt;
    logic [LenW-1:0] cnt_inc;
    logic [LenW-1:0] len_clamped;
    logic [31:0]     acc;
    logic [31:0]     mac_data;
    logic [31:0]     mac_weight;
    logic [31:0]     mac_acc;
    logic            spurious;

    // Requested lengths beyond MaxLen are treated as MaxLen; cnt_inc never exceeds len.
    assign len_clamped = (len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : len_i;
    assign cnt_inc     = cnt + LenW'(1);

    // Sequencer FSM: one issue per fetched pair, waits for the MAC result before the next fetch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            len        <= '0;
            cnt        <= '0;
            acc        <= '0;
            mac_data   <= '0;
            mac_weight <= '0;
            mac_acc    <= '0;
            spurious   <= 1'b0;
        end else begin
            // A MAC result outside WAIT is dropped but remembered until the next reset.
            if (mac_finished_i && (state != S_WAIT)) begin
                spurious <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        len   <= len_clamped;
                        acc   <= acc_init_i;
                        cnt   <= '0;
                        state <= (len_clamped == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (in_valid_i) begin
                        mac_data   <= data_i;
                        mac_weight <= weight_i;
                        mac_acc    <= acc;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_finished_i) begin
                        acc   <= mac_acc_i;
                        cnt   <= cnt_inc;
                        state <= (cnt_inc == len) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = (state == S_FETCH);
    assign mac_valid_o  = (state == S_ISSUE);
    assign res_valid_o  = (state == S_DONE);
    assign busy_o       = (state != S_IDLE);
    assign mac_data_o   = mac_data;
    assign mac_weight_o = mac_weight;
    assign mac_acc_o    = mac_acc;
    assign res_o        = acc;
    assign spurious_o   = spurious;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed testbench for mac_dot_sequencer with a latency-configurable integer-exact MAC model.
module tb_mac_dot_sequencer;

    localparam int MaxLen = 256;
    localparam int LenW   = $clog2(MaxLen + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [LenW-1:0] len = '0;
    logic [31:0]     acc_init = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     data = '0;
    logic [31:0]     weight = '0;
    logic            mac_valid;
    logic [31:0]     mac_data;
    logic [31:0]     mac_weight;
    logic [31:0]     mac_acc;
    logic            mac_finished;
    logic [31:0]     mac_acc_in;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [31:0]     res;
    logic            busy;
    logic            spurious;

    logic            inj_fin = 1'b0;
    logic            model_fin;
    logic [31:0]     model_res;
    logic            model_busy;
    int              rem;
    int              lat = 2;

    int              errors = 0;
    int              checks = 0;
    int              timeouts = 0;
    int              cyc = 0;
    int              issue_cnt = 0;
    int              ready_cnt = 0;
    int              spacing_bad = 0;
    int              last_cyc = 0;
    logic            have_last = 1'b0;
    logic            spacing_on = 1'b0;
    logic [31:0]     last_issue_acc = '0;

    always #5 clk = ~clk;

    assign mac_finished = model_fin | inj_fin;
    assign mac_acc_in   = inj_fin ? 32'hDEADBEEF : model_res;

    mac_dot_sequencer #(.MaxLen(MaxLen)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .len_i          (len),
        .acc_init_i     (acc_init),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .data_i         (data),
        .weight_i       (weight),
        .mac_valid_o    (mac_valid),
        .mac_data_o     (mac_data),
        .mac_weight_o   (mac_weight),
        .mac_acc_o      (mac_acc),
        .mac_finished_i (mac_finished),
        .mac_acc_i      (mac_acc_in),
        .res_valid_o    (res_valid),
        .res_ready_i    (res_ready),
        .res_o          (res),
        .busy_o         (busy),
        .spurious_o     (spurious)
    );

    // Exact for non-negative integer-valued floats below 2^24.
    function automatic int fp2int(input logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({8'd0, 1'b1, f[22:0]});
        return m >>> (23 - e);
    endfunction

    function automatic logic [31:0] int2fp(input int v);
        int p;
        int m;
        if (v == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 31; i++) begin
            if (v[i]) p = i;
        end
        m = (v << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(p + 127), m[22:0]};
    endfunction

    // MAC model: result pulse arrives lat cycles after the issue cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_fin  <= 1'b0;
            model_res  <= '0;
            model_busy <= 1'b0;
            rem        <= 0;
        end else begin
            model_fin <= 1'b0;
            if (mac_valid) begin
                model_res <= int2fp(fp2int(mac_data) * fp2int(mac_weight) + fp2int(mac_acc));
                if (lat <= 1) begin
                    model_fin <= 1'b1;
                end else begin
                    rem        <= lat - 1;
                    model_busy <= 1'b1;
                end
            end else if (model_busy) begin
                if (rem == 1) begin
                    model_fin  <= 1'b1;
                    model_busy <= 1'b0;
                end
                rem <= rem - 1;
            end
        end
    end

    // Monitor sampled on the falling edge: issue count, spacing, ready occupancy.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (in_ready) ready_cnt <= ready_cnt + 1;
        if (mac_valid) begin
            issue_cnt      <= issue_cnt + 1;
            last_issue_acc <= mac_acc;
            if (spacing_on && have_last && ((cyc - last_cyc) != lat + 2)) begin
                spacing_bad <= spacing_bad + 1;
            end
            last_cyc <= cyc;
        end
        if (!spacing_on) have_last <= 1'b0;
        else if (mac_valid) have_last <= 1'b1;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [LenW-1:0] k, input logic [31:0] a0);
        start    = 1'b1;
        len      = k;
        acc_init = a0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] d, input logic [31:0] w);
        int n;
        in_valid = 1'b1;
        data     = d;
        weight   = w;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) timeouts++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!res_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) timeouts++;
    endtask

    task automatic ack_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        int ib;
        int rb;
        int tb;
        int sb;
        int bad;
        logic [31:0] held;

        // Reset state
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd0);
        check_output("rst_mac_valid", 32'(mac_valid), 32'd0);
        check_output("rst_res_valid", 32'(res_valid), 32'd0);
        check_output("rst_res", res, 32'd0);
        check_output("rst_mac_acc", mac_acc, 32'd0);
        check_output("rst_spurious", 32'(spurious), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Step 1: K=2, 1*2 + 2*3 = 8.0
        $display("[TB] step 1: K=2 basic dot product");
        lat = 2; ib = issue_cnt; tb = timeouts;
        apply_stimulus(LenW'(2), 32'h0000_0000);
        check_output("s1_busy", 32'(busy), 32'd1);
        send_pair(32'h3F80_0000, 32'h4000_0000);
        send_pair(32'h4000_0000, 32'h4040_0000);
        wait_result();
        check_output("s1_res", res, 32'h4100_0000);
        check_output("s1_issues", 32'(issue_cnt - ib), 32'd2);
        check_output("s1_second_acc", last_issue_acc, 32'h4000_0000);
        check_output("s1_timeouts", 32'(timeouts - tb), 32'd0);
        ack_result();
        check_output("s1_idle", 32'(busy), 32'd0);

        // Step 2: K=0 passes acc_init straight through; start during DONE+ready ignored
        $display("[TB] step 2: K=0");
        ib = issue_cnt; rb = ready_cnt;
        apply_stimulus(LenW'(0), 32'h3FC0_0000);
        check_output("s2_res_valid", 32'(res_valid), 32'd1);
        check_output("s2_res", res, 32'h3FC0_0000);
        res_ready = 1'b1;
        start     = 1'b1;
        len       = LenW'(1);
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        check_output("s2_start_in_done_ignored", 32'(busy), 32'd0);
        check_output("s2_no_issue", 32'(issue_cnt - ib), 32'd0);
        check_output("s2_no_ready", 32'(ready_cnt - rb), 32'd0);

        // Step 3: K=3 with an in_valid gap and consumer back-pressure, 1+2+3 = 6.0
        $display("[TB] step 3: K=3 with stalls");
        ib = issue_cnt; tb = timeouts;
        apply_stimulus(LenW'(3), 32'h0000_0000);
        send_pair(32'h3F80_0000, 32'h3F80_0000);
        repeat (5) @(negedge clk);
        check_output("s3_fetch_stall", 32'(in_ready), 32'd1);
        check_output("s3_stall_issues", 32'(issue_cnt - ib), 32'd1);
        send_pair(32'h4000_0000, 32'h3F80_0000);
        send_pair(32'h4040_0000, 32'h3F80_0000);
        wait_result();
        held = res;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!res_valid || res !== held) bad++;
        end
        check_output("s3_hold_stable", 32'(bad), 32'd0);
        check_output("s3_res", res, 32'h40C0_0000);
        check_output("s3_issues", 32'(issue_cnt - ib), 32'd3);
        check_output("s3_timeouts", 32'(timeouts - tb), 32'd0);
        ack_result();

        // Step 4: latency sweep at K=MaxLen, 256 * 1.0*1.0 = 256.0; last run requests 300 (clamped)
        for (int li = 0; li < 3; li++) begin
            lat = (li == 0) ? 1 : ((li == 1) ? 2 : 7);
            $display("[TB] step 4: K=%0d latency %0d", MaxLen, lat);
            ib = issue_cnt; sb = spacing_bad; tb = timeouts;
            spacing_on = 1'b1;
            apply_stimulus((li == 2) ? LenW'(300) : LenW'(MaxLen), 32'h0000_0000);
            for (int p = 0; p < MaxLen; p++) send_pair(32'h3F80_0000, 32'h3F80_0000);
            wait_result();
            spacing_on = 1'b0;
            check_output("s4_res", res, 32'h4380_0000);
            check_output("s4_issues", 32'(issue_cnt - ib), 32'(MaxLen));
            check_output("s4_spacing", 32'(spacing_bad - sb), 32'd0);
            check_output("s4_timeouts", 32'(timeouts - tb), 32'd0);
            ack_result();
        end

        // Step 5: spurious MAC results in IDLE and FETCH; start during WAIT ignored; 1 + 3*2 = 7.0
        $display("[TB] step 5: spurious finish and ignored start");
        lat = 2; ib = issue_cnt; tb = timeouts;
        inj_fin = 1'b1;
        @(negedge clk);
        inj_fin = 1'b0;
        check_output("s5_spurious_idle", 32'(spurious), 32'd1);
        check_output("s5_idle_state", 32'(busy), 32'd0);
        check_output("s5_idle_acc", res, 32'h4380_0000);
        apply_stimulus(LenW'(1), 32'h3F80_0000);
        inj_fin = 1'b1;
        @(negedge clk);
        inj_fin = 1'b0;
        check_output("s5_fetch_state", 32'(in_ready), 32'd1);
        check_output("s5_fetch_acc", res, 32'h3F80_0000);
        send_pair(32'h4040_0000, 32'h4000_0000);
        @(negedge clk);
        start = 1'b1;
        len   = LenW'(5);
        @(negedge clk);
        start = 1'b0;
        wait_result();
        check_output("s5_res", res, 32'h40E0_0000);
        check_output("s5_issues", 32'(issue_cnt - ib), 32'd1);
        check_output("s5_spurious_sticky", 32'(spurious), 32'd1);
        check_output("s5_timeouts", 32'(timeouts - tb), 32'd0);
        ack_result();

        // Step 6: reset during WAIT of the third pair (cnt=2), then a clean K=1 run, 2 + 3*3 = 11.0
        $display("[TB] step 6: reset mid-operation");
        lat = 7; tb = timeouts;
        apply_stimulus(LenW'(4), 32'h0000_0000);
        send_pair(32'h3F80_0000, 32'h3F80_0000);
        send_pair(32'h3F80_0000, 32'h3F80_0000);
        send_pair(32'h3F80_0000, 32'h3F80_0000);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("s6_busy", 32'(busy), 32'd0);
        check_output("s6_in_ready", 32'(in_ready), 32'd0);
        check_output("s6_mac_valid", 32'(mac_valid), 32'd0);
        check_output("s6_res_valid", 32'(res_valid), 32'd0);
        check_output("s6_res", res, 32'd0);
        check_output("s6_mac_data", mac_data, 32'd0);
        check_output("s6_mac_acc", mac_acc, 32'd0);
        check_output("s6_spurious", 32'(spurious), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ib = issue_cnt;
        apply_stimulus(LenW'(1), 32'h4000_0000);
        send_pair(32'h4040_0000, 32'h4040_0000);
        wait_result();
        check_output("s6_rerun_res", res, 32'h4130_0000);
        check_output("s6_rerun_issues", 32'(issue_cnt - ib), 32'd1);
        check_output("s6_rerun_spurious", 32'(spurious), 32'd0);
        check_output("s6_timeouts", 32'(timeouts - tb), 32'd0);
        ack_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
